boot_ctrl: RTL and testbench

- Boot-load sequencer for the MIPS pipeline instruction memory.
- On a start pulse it raises the sync request to the instruction transmitter and accepts the acknowledged instruction stream until `last`. It writes each word into IMEM at consecutive addresses.
- Holds the CPU core in reset until the load completes, and flags timeout or overflow errors.

---
 rtl/boot_ctrl_pkg.sv | 10 +
 rtl/boot_timeout.sv | 18 +
 rtl/boot_ctrl.sv | 83 ++++++++
 tb/tb_boot_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/boot_ctrl_pkg.sv
// boot_ctrl_pkg: shared word width and sequencer state encodings
package boot_ctrl_pkg;
  localparam int BC_IWIDTH = 32;
  typedef enum logic [1:0] {
    BC_IDLE = 2'd0,
    BC_LOAD = 2'd1,
    BC_DONE = 2'd2,
    BC_ERR  = 2'd3
  } bc_state_e;
endpackage

// File: rtl/boot_timeout.sv
// boot_timeout: saturating no-ack counter; expire flags the cycle that reaches TIMEOUT
module boot_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt;
  // count consecutive idle cycles, saturating at TIMEOUT
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && cnt != TW'(TIMEOUT)) cnt <= cnt + 1'b1;
  assign expire = inc && (cnt >= TW'(TIMEOUT - 1));
endmodule

// File: rtl/boot_ctrl.sv
// boot_ctrl: loads an acknowledged instruction stream into IMEM while holding the CPU in reset
module boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int IWIDTH    = BC_IWIDTH,
  parameter int AWIDTH    = 10,
  parameter int MAX_WORDS = 1024,
  parameter int TIMEOUT   = 16
) (
  input  logic              b_clk,
  input  logic              b_rst,
  input  logic              b_i_start,
  output logic              b_o_syn,
  input  logic [IWIDTH-1:0] b_i_instr,
  input  logic              b_i_last,
  input  logic              b_i_ack,
  output logic              b_o_we,
  output logic [AWIDTH-1:0] b_o_waddr,
  output logic [IWIDTH-1:0] b_o_wdata,
  output logic              b_o_cpu_rst,
  output logic              b_o_busy,
  output logic              b_o_done,
  output logic              b_o_err,
  output logic [AWIDTH:0]   b_o_count
);
  bc_state_e state;
  logic      expire;
  logic      last_slot;
  assign last_slot = b_o_count == (AWIDTH+1)'(MAX_WORDS - 1);
  boot_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (b_clk),
    .rst   (b_rst),
    .clr   (state != BC_LOAD || b_i_ack),
    .inc   (state == BC_LOAD && !b_i_ack),
    .expire(expire)
  );
  // sequencer and IMEM write register; final word and state change share one update
  always_ff @(posedge b_clk)
    if (b_rst) begin
      state       <= BC_IDLE;
      b_o_syn     <= 1'b0;
      b_o_we      <= 1'b0;
      b_o_waddr   <= '0;
      b_o_wdata   <= '0;
      b_o_cpu_rst <= 1'b1;
      b_o_busy    <= 1'b0;
      b_o_done    <= 1'b0;
      b_o_err     <= 1'b0;
      b_o_count   <= '0;
    end else begin
      b_o_we <= 1'b0;
      if (state != BC_LOAD) begin
        if (b_i_start) begin
          state       <= BC_LOAD;
          b_o_syn     <= 1'b1;
          b_o_busy    <= 1'b1;
          b_o_done    <= 1'b0;
          b_o_err     <= 1'b0;
          b_o_cpu_rst <= 1'b1;
          b_o_count   <= '0;
          b_o_waddr   <= '0;
        end
      end else if (b_i_ack) begin
        b_o_we    <= 1'b1;
        b_o_wdata <= b_i_instr;
        b_o_waddr <= b_o_count[AWIDTH-1:0];
        b_o_count <= b_o_count + 1'b1;
        if (b_i_last || last_slot) begin
          state       <= b_i_last ? BC_DONE : BC_ERR;
          b_o_syn     <= 1'b0;
          b_o_busy    <= 1'b0;
          b_o_done    <= b_i_last;
          b_o_err     <= !b_i_last;
          b_o_cpu_rst <= !b_i_last;
        end
      end else if (expire) begin
        state    <= BC_ERR;
        b_o_syn  <= 1'b0;
        b_o_busy <= 1'b0;
        b_o_err  <= 1'b1;
      end
    end
endmodule

// File: tb/tb_boot_ctrl.sv
// tb_boot_ctrl: directed and random checks of two boot_ctrl builds against a behavioural model
module tb_boot_ctrl;
  logic        b_clk = 1'b0;
  logic        b_rst = 1'b1, b_i_start = 1'b0, b_i_ack = 1'b0, b_i_last = 1'b0;
  logic [31:0] b_i_instr = '0;
  logic        syn0, we0, crst0, busy0, done0, err0;
  logic        syn1, we1, crst1, busy1, done1, err1;
  logic [9:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [10:0] count0, count1;
  int n_chk = 0, n_fail = 0;

  typedef struct packed {
    logic        load, done, err;
    logic [31:0] cnt, idle, waddr, wdata;
    logic        syn, we, busy, crst;
  } mdl_t;
  mdl_t m0, m1;

  always #5 b_clk = ~b_clk;

  boot_ctrl u_dut (
    .b_clk(b_clk), .b_rst(b_rst), .b_i_start(b_i_start), .b_o_syn(syn0),
    .b_i_instr(b_i_instr), .b_i_last(b_i_last), .b_i_ack(b_i_ack),
    .b_o_we(we0), .b_o_waddr(waddr0), .b_o_wdata(wdata0), .b_o_cpu_rst(crst0),
    .b_o_busy(busy0), .b_o_done(done0), .b_o_err(err0), .b_o_count(count0)
  );

  boot_ctrl #(.MAX_WORDS(4)) u_dut4 (
    .b_clk(b_clk), .b_rst(b_rst), .b_i_start(b_i_start), .b_o_syn(syn1),
    .b_i_instr(b_i_instr), .b_i_last(b_i_last), .b_i_ack(b_i_ack),
    .b_o_we(we1), .b_o_waddr(waddr1), .b_o_wdata(wdata1), .b_o_cpu_rst(crst1),
    .b_o_busy(busy1), .b_o_done(done1), .b_o_err(err1), .b_o_count(count1)
  );

  function automatic mdl_t step(mdl_t m, logic rst, logic start, logic ack, logic last,
                                logic [31:0] instr, int maxw);
    mdl_t n = m;
    n.we = 1'b0;
    if (rst) begin
      n = '0;
      n.crst = 1'b1;
    end else if (!m.load) begin
      if (start) begin
        n.load = 1'b1; n.done = 1'b0; n.err = 1'b0; n.syn = 1'b1; n.busy = 1'b1;
        n.crst = 1'b1; n.cnt = 0; n.idle = 0; n.waddr = 0;
      end
    end else if (ack) begin
      n.we = 1'b1; n.wdata = instr; n.waddr = m.cnt; n.cnt = m.cnt + 1; n.idle = 0;
      if (last || n.cnt == 32'(maxw)) begin
        n.load = 1'b0; n.syn = 1'b0; n.busy = 1'b0;
        n.done = last; n.err = !last; n.crst = !last;
      end
    end else begin
      n.idle = m.idle + 1;
      if (n.idle == 16) begin
        n.load = 1'b0; n.syn = 1'b0; n.busy = 1'b0; n.err = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(string tag, mdl_t m, logic syn, logic we, logic [9:0] waddr,
                     logic [31:0] wdata, logic crst, logic busy, logic done, logic err,
                     logic [10:0] count);
    chk({tag, "_syn"}, 32'(syn), 32'(m.syn));
    chk({tag, "_we"}, 32'(we), 32'(m.we));
    chk({tag, "_waddr"}, 32'(waddr), m.waddr);
    chk({tag, "_wdata"}, wdata, m.wdata);
    chk({tag, "_cpu_rst"}, 32'(crst), 32'(m.crst));
    chk({tag, "_busy"}, 32'(busy), 32'(m.busy));
    chk({tag, "_done"}, 32'(done), 32'(m.done));
    chk({tag, "_err"}, 32'(err), 32'(m.err));
    chk({tag, "_count"}, 32'(count), m.cnt);
  endtask

  task automatic drv(logic rst, logic start, logic ack, logic last, logic [31:0] instr);
    b_rst = rst; b_i_start = start; b_i_ack = ack; b_i_last = last; b_i_instr = instr;
    @(posedge b_clk);
    m0 = step(m0, rst, start, ack, last, instr, 1024);
    m1 = step(m1, rst, start, ack, last, instr, 4);
    #1;
    cmp("d1024", m0, syn0, we0, waddr0, wdata0, crst0, busy0, done0, err0, count0);
    cmp("d4", m1, syn1, we1, waddr1, wdata1, crst1, busy1, done1, err1, count1);
  endtask

  initial begin
    m0 = '0; m1 = '0;
    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("reset_cpu_rst", 32'(crst0), 32'd1);
    chk("reset_count", 32'(count0), 32'd0);
    // six-word load ending on last
    drv(0, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) drv(0, 0, 1, i == 6, 32'h2008_0000 + 32'(i));
    chk("load6_done", 32'(done0), 32'd1);
    chk("load6_syn", 32'(syn0), 32'd0);
    chk("load6_addr", 32'(waddr0), 32'd5);
    chk("load6_data", wdata0, 32'h2008_0006);
    chk("load6_count", 32'(count0), 32'd6);
    chk("load6_ovf4", 32'(err1), 32'd1);
    drv(0, 0, 1, 1, 32'hdead_beef);
    chk("done_no_write", 32'(we0), 32'd0);
    // two words then a timeout
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 1, 0, 32'h1111_0001);
    drv(0, 0, 1, 0, 32'h1111_0002);
    for (int i = 1; i <= 15; i++) drv(0, 0, 0, 0, 0);
    chk("tmo_not_yet", 32'(err0), 32'd0);
    drv(0, 0, 0, 0, 0);
    chk("tmo_err", 32'(err0), 32'd1);
    chk("tmo_count", 32'(count0), 32'd2);
    chk("tmo_cpu_rst", 32'(crst0), 32'd1);
    // start during load is ignored
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 1, 0, 32'h3000_0000);
    drv(0, 1, 1, 0, 32'h3000_0001);
    drv(0, 1, 1, 1, 32'h3000_0002);
    chk("restart_ignored_addr", 32'(waddr0), 32'd2);
    drv(0, 1, 0, 0, 0);
    chk("reload_cpu_rst", 32'(crst0), 32'd1);
    chk("reload_count", 32'(count0), 32'd0);
    // reset mid-load after the third word
    for (int i = 0; i < 3; i++) drv(0, 0, 1, 0, 32'h4000_0000 + 32'(i));
    drv(1, 0, 1, 0, 32'h4000_0003);
    chk("midrst_we", 32'(we0), 32'd0);
    chk("midrst_syn", 32'(syn0), 32'd0);
    drv(1, 1, 0, 0, 0);
    chk("rst_beats_start", 32'(busy0), 32'd0);
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 1, 0, 32'h5000_0000);
    chk("reload_addr0", 32'(waddr0), 32'd0);
    // overflow and exact-fit on the four-word build
    drv(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drv(0, 0, 1, 0, 32'h6000_0000 + 32'(i));
    chk("ovf4_err", 32'(err1), 32'd1);
    chk("ovf4_count", 32'(count1), 32'd4);
    drv(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv(0, 0, 1, i == 3, 32'h7000_0000 + 32'(i));
    chk("fit4_done", 32'(done1), 32'd1);
    chk("fit4_err", 32'(err1), 32'd0);
    // random traffic with varying ack density
    for (int s = 0; s < 40; s++) begin
      int p;
      p = (s % 5 == 0) ? 0 : int'($urandom_range(10, 100));
      for (int i = 0; i < 50; i++) begin
        logic a;
        a = ($urandom % 100) < p;
        drv(($urandom % 200) == 0, ($urandom % 15) == 0, a, a && ($urandom % 8) == 0, $urandom);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
